// File: rtl/edge_view_controller.sv
// View-mode sequencer for the Sobel edge display path: pixel position tracking,
// frame-aligned mode switching, threshold control and final pixel selection.
module edge_view_controller #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned PIPE_DELAY  = 2,
  parameter int unsigned BORDER      = 2,
  parameter logic [3:0]  DEFAULT_THR = 4'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [11:0] video_raw,
  input  logic [11:0] video_edge,
  input  logic        btn_mode,
  input  logic        btn_thr_up,
  input  logic        btn_thr_down,
  output logic [11:0] video_out,
  output logic [1:0]  mode,
  output logic [3:0]  threshold,
  output logic        frame_start,
  output logic        mode_pending
);

  typedef enum logic {StRun, StPending} state_t;

  state_t      state;
  logic [1:0]  next_mode;
  logic [9:0]  x, y;
  logic [11:0] raw_sr [PIPE_DELAY];
  logic [11:0] raw_d;
  logic [3:0]  e;
  logic        at_origin, commit, border, hit;
  logic [1:0]  mode_eff;
  logic [11:0] pixel;
  logic        unused_edge;

  assign unused_edge = ^video_edge[7:0];
  assign e           = video_edge[11:8];
  assign raw_d       = raw_sr[PIPE_DELAY-1];
  assign at_origin   = (x == 10'd0) && (y == 10'd0);
  assign commit      = (state == StPending) && ready && at_origin;
  // The committing pixel is already rendered in the new mode.
  assign mode_eff    = commit ? next_mode : mode;
  assign border      = (x < 10'(BORDER)) || (y < 10'(BORDER));
  assign hit         = (e >= threshold);

  always_comb begin
    pixel = raw_d;
    unique case (mode_eff)
      2'd0: pixel = raw_d;
      2'd1: pixel = border ? 12'h000 : {e, e, e};
      2'd2: pixel = (border || !hit) ? 12'h000 : 12'hFFF;
      2'd3: pixel = (!border && hit) ? 12'h0F0 : raw_d;
      default: pixel = raw_d;
    endcase
  end

  // Mode FSM; a request landing on the commit cycle re-arms from the committed mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StRun;
      mode         <= 2'd0;
      next_mode    <= 2'd0;
      mode_pending <= 1'b0;
    end else begin
      unique case (state)
        StRun: begin
          if (btn_mode) begin
            state        <= StPending;
            next_mode    <= mode + 2'd1;
            mode_pending <= 1'b1;
          end
        end
        StPending: begin
          if (commit) begin
            mode <= next_mode;
            if (btn_mode) begin
              next_mode <= next_mode + 2'd1;
            end else begin
              state        <= StRun;
              mode_pending <= 1'b0;
            end
          end else if (btn_mode) begin
            next_mode <= next_mode + 2'd1;
          end
        end
        default: state <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      threshold <= DEFAULT_THR;
    end else if (btn_thr_up && !btn_thr_down && threshold != 4'hF) begin
      threshold <= threshold + 4'd1;
    end else if (btn_thr_down && !btn_thr_up && threshold != 4'h0) begin
      threshold <= threshold - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= 10'd0;
      y           <= 10'd0;
      video_out   <= 12'h000;
      frame_start <= 1'b0;
      for (int i = 0; i < int'(PIPE_DELAY); i++) raw_sr[i] <= 12'h000;
    end else begin
      frame_start <= ready && at_origin;
      if (ready) begin
        video_out <= pixel;
        raw_sr[0] <= video_raw;
        for (int i = 1; i < int'(PIPE_DELAY); i++) raw_sr[i] <= raw_sr[i-1];
        if (x == 10'(WIDTH - 1)) begin
          x <= 10'd0;
          y <= (y == 10'(HEIGHT - 1)) ? 10'd0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_view_controller.sv
// Scoreboard bench for edge_view_controller on a reduced 16x8 frame.
module tb_edge_view_controller;

  localparam int         W  = 16;
  localparam int         H  = 8;
  localparam int         PD = 2;
  localparam int         BD = 2;
  localparam logic [3:0] DT = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic [11:0] video_raw = '0;
  logic [11:0] video_edge = '0;
  logic        btn_mode = 1'b0;
  logic        btn_thr_up = 1'b0;
  logic        btn_thr_down = 1'b0;
  logic [11:0] video_out;
  logic [1:0]  mode;
  logic [3:0]  threshold;
  logic        frame_start;
  logic        mode_pending;

  always #5 clk = ~clk;

  edge_view_controller #(
    .WIDTH(W), .HEIGHT(H), .PIPE_DELAY(PD), .BORDER(BD), .DEFAULT_THR(DT)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .video_raw(video_raw),
    .video_edge(video_edge), .btn_mode(btn_mode), .btn_thr_up(btn_thr_up),
    .btn_thr_down(btn_thr_down), .video_out(video_out), .mode(mode),
    .threshold(threshold), .frame_start(frame_start), .mode_pending(mode_pending)
  );

  int          checks = 0;
  int          errors = 0;
  int          fs_cnt = 0;
  logic [11:0] expq[$];
  logic [11:0] hold_exp = '0;
  logic        pend_chk = 1'b0;

  // Reference model state
  int          bx, by;
  logic [1:0]  bmode, bnext;
  logic        bpend, efs;
  logic [3:0]  bthr;
  logic [11:0] hist [PD];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic [1:0] m, input logic [11:0] rd,
                                          input logic [3:0] e, input logic [3:0] t,
                                          input logic brd);
    case (m)
      2'd0:    return rd;
      2'd1:    return brd ? 12'h000 : {e, e, e};
      2'd2:    return (brd || e < t) ? 12'h000 : 12'hFFF;
      default: return (!brd && e >= t) ? 12'h0F0 : rd;
    endcase
  endfunction

  task automatic model_reset();
    bx = 0; by = 0; bmode = 2'd0; bnext = 2'd0; bpend = 1'b0; bthr = DT; efs = 1'b0;
    for (int i = 0; i < PD; i++) hist[i] = '0;
  endtask

  task automatic tick(input logic rdy, input logic rst, input logic [11:0] raw,
                      input logic [11:0] edg, input logic bm, input logic up, input logic dn);
    logic       boundary;
    logic [1:0] m;
    reset = rst; ready = rdy; video_raw = raw; video_edge = edg;
    btn_mode = bm; btn_thr_up = up; btn_thr_down = dn;
    if (rst) begin
      model_reset();
    end else begin
      boundary = (bx == 0 && by == 0);
      efs = rdy && boundary;
      if (rdy) begin
        m = (bpend && boundary) ? bnext : bmode;
        expq.push_back(exp_pix(m, hist[PD-1], edg[11:8], bthr, (bx < BD) || (by < BD)));
        for (int i = PD - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = raw;
        if (bpend && boundary) begin bmode = bnext; bpend = 1'b0; end
        if (bx == W - 1) begin bx = 0; by = (by == H - 1) ? 0 : by + 1; end
        else bx++;
      end
      if (bm) begin
        if (bpend) bnext = bnext + 2'd1;
        else begin bpend = 1'b1; bnext = bmode + 2'd1; end
      end
      if (up && !dn && bthr != 4'hF) bthr++;
      else if (dn && !up && bthr != 4'h0) bthr--;
    end
    @(posedge clk); #1;
    reset = 1'b0; ready = 1'b0; btn_mode = 1'b0; btn_thr_up = 1'b0; btn_thr_down = 1'b0;
    if (rst) hold_exp = '0;
    check("frame_start", {31'd0, frame_start}, {31'd0, efs});
    check("mode", {30'd0, mode}, {30'd0, bmode});
    check("mode_pending", {31'd0, mode_pending}, {31'd0, bpend});
    check("threshold", {28'd0, threshold}, {28'd0, bthr});
  endtask

  task automatic strobe(input logic [11:0] raw, input logic [11:0] edg, input logic bm);
    tick(1'b1, 1'b0, raw, edg, bm, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic bm, input logic up, input logic dn);
    tick(1'b0, 1'b0, 12'h000, 12'h000, bm, up, dn);
  endtask

  task automatic run_to(input int tx, input int ty);
    int guard = 0;
    while (!(bx == tx && by == ty)) begin
      strobe(12'(bx * 7 + by), 12'h500, 1'b0);
      guard++;
      if (guard > 4 * W * H) begin
        check("run_to_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  // Monitor: each ready strobe yields one pixel on the following edge; otherwise hold.
  always @(posedge clk) pend_chk <= ready && !reset;

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (pend_chk) begin
      if (expq.size() == 0) check("unexpected_pixel", 32'd1, 32'd0);
      else begin
        hold_exp = expq.pop_front();
        check("pixel", {20'd0, video_out}, {20'd0, hold_exp});
      end
    end else begin
      check("hold", {20'd0, video_out}, {20'd0, hold_exp});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) tick(1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
    check("rst_video_out", {20'd0, video_out}, 32'h0);
    check("rst_mode", {30'd0, mode}, 32'd0);
    check("rst_threshold", {28'd0, threshold}, 32'd8);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_mode_pending", {31'd0, mode_pending}, 32'd0);

    // Two PASS frames with idle gaps
    for (int i = 0; i < 2 * W * H; i++) begin
      if (i % 7 == 3) idle(1'b0, 1'b0, 1'b0);
      strobe(12'(i), 12'($urandom), 1'b0);
      if (i == 5) check("pass_delay", {20'd0, video_out}, 32'd3);
    end
    check("frame_start_count", fs_cnt, 32'd2);

    // Mode request deferred to frame boundary
    run_to(10, 5);
    strobe(12'h321, 12'h500, 1'b1);
    check("req_pending", {31'd0, mode_pending}, 32'd1);
    run_to(0, 0);
    check("mode_before_boundary", {30'd0, mode}, 32'd0);
    strobe(12'h111, 12'hA00, 1'b0);
    check("edge_first_pixel", {20'd0, video_out}, 32'h000);
    check("edge_mode", {30'd0, mode}, 32'd1);
    check("edge_pending_clr", {31'd0, mode_pending}, 32'd0);
    run_to(4, 3);
    strobe(12'h111, 12'hA00, 1'b0);
    check("edge_gray", {20'd0, video_out}, 32'hAAA);

    // Three requests in one frame plus one on the boundary cycle
    tick(1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
    run_to(3, 3);
    strobe(12'h222, 12'h000, 1'b1);
    idle(1'b1, 1'b0, 1'b0);
    run_to(8, 3);
    strobe(12'h222, 12'h000, 1'b1);
    run_to(0, 0);
    strobe(12'h333, 12'h000, 1'b1);
    check("boundary_mode", {30'd0, mode}, 32'd3);
    check("boundary_pending", {31'd0, mode_pending}, 32'd1);
    run_to(0, 0);
    strobe(12'h333, 12'h000, 1'b0);
    check("wrap_mode", {30'd0, mode}, 32'd0);

    // BINARY at threshold 8
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    run_to(0, 0);
    strobe(12'h000, 12'h000, 1'b0);
    check("binary_mode", {30'd0, mode}, 32'd2);
    run_to(5, 3);
    strobe(12'h000, 12'h700, 1'b0);
    check("bin_e7", {20'd0, video_out}, 32'h000);
    strobe(12'h000, 12'h800, 1'b0);
    check("bin_e8", {20'd0, video_out}, 32'hFFF);
    run_to(1, 4);
    strobe(12'h000, 12'hF00, 1'b0);
    check("bin_border_x", {20'd0, video_out}, 32'h000);
    run_to(7, 1);
    strobe(12'h000, 12'hF00, 1'b0);
    check("bin_border_y", {20'd0, video_out}, 32'h000);

    // Threshold saturation
    repeat (10) idle(1'b0, 1'b1, 1'b0);
    check("thr_sat_hi", {28'd0, threshold}, 32'd15);
    repeat (20) idle(1'b0, 1'b0, 1'b1);
    check("thr_sat_lo", {28'd0, threshold}, 32'd0);
    run_to(4, 4);
    strobe(12'h000, 12'h000, 1'b0);
    check("bin_thr0", {20'd0, video_out}, 32'hFFF);
    idle(1'b0, 1'b1, 1'b1);
    check("thr_both_0", {28'd0, threshold}, 32'd0);
    repeat (4) idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    check("thr_both_4", {28'd0, threshold}, 32'd4);

    // OVERLAY at threshold 4
    idle(1'b1, 1'b0, 1'b0);
    run_to(0, 0);
    strobe(12'h000, 12'h000, 1'b0);
    check("overlay_mode", {30'd0, mode}, 32'd3);
    run_to(4, 3);
    strobe(12'h123, 12'h000, 1'b0);
    strobe(12'h456, 12'h000, 1'b0);
    strobe(12'h000, 12'h500, 1'b0);
    check("ovl_hit", {20'd0, video_out}, 32'h0F0);
    strobe(12'h123, 12'h000, 1'b0);
    strobe(12'h000, 12'h000, 1'b0);
    strobe(12'h000, 12'h300, 1'b0);
    check("ovl_miss", {20'd0, video_out}, 32'h123);

    // Mid-frame reset
    run_to(12, 4);
    tick(1'b1, 1'b1, 12'h999, 12'hF00, 1'b0, 1'b0, 1'b0);
    check("mid_rst_video_out", {20'd0, video_out}, 32'h0);
    check("mid_rst_mode", {30'd0, mode}, 32'd0);
    check("mid_rst_threshold", {28'd0, threshold}, 32'd8);
    check("mid_rst_pending", {31'd0, mode_pending}, 32'd0);
    check("mid_rst_frame_start", {31'd0, frame_start}, 32'd0);
    strobe(12'h777, 12'hF00, 1'b0);
    check("post_rst_origin", {31'd0, frame_start}, 32'd1);
    check("post_rst_pixel", {20'd0, video_out}, 32'h000);

    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    check("queue_empty", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
